// File: rtl/adc_rst_seq_pkg.sv
// Shared state encodings, timing defaults and output decode for the ADC capture reset sequencer.
package adc_rst_seq_pkg;

  localparam logic [2:0] S_RST     = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_DLYRST  = 3'd2;
  localparam logic [2:0] S_WAITRDY = 3'd3;
  localparam logic [2:0] S_SRDRST  = 3'd4;
  localparam logic [2:0] S_LOCKED  = 3'd5;

  localparam int RETRY_MAX = 15;

  localparam int DEF_SETTLE_CYC  = 256;
  localparam int DEF_DLYRST_CYC  = 16;
  localparam int DEF_RDY_TIMEOUT = 4096;
  localparam int DEF_SRDRST_CYC  = 8;

  typedef struct packed {
    logic dly_rst;
    logic serdes_rst;
    logic lockeda;
  } seq_out_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Outputs are a pure function of the state they are registered alongside.
  function automatic seq_out_t decode_out(input logic [2:0] st);
    seq_out_t o;
    o.dly_rst    = (st == S_RST) || (st == S_SETTLE) || (st == S_DLYRST);
    o.serdes_rst = (st != S_LOCKED);
    o.lockeda    = (st == S_LOCKED);
    return o;
  endfunction

endpackage

// File: rtl/adc_rst_seq_rst_sync.sv
// rst_sync3: async-assert, clocked-release shift chain; with RST_VAL=0 and STAGES=2 it is a plain CDC synchroniser.
module rst_sync3 #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic arst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) ff <= {STAGES{RST_VAL}};
    else      ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/adc_rst_seq.sv
// Reset/lock sequencer for the ADC capture path: IDELAYCTRL reset, RDY wait with retry, ISERDES reset, lock.
// Optional ADC_RST_SEQ_RDY_MON_EN: drop lock when synchronised dly_rdy is low for 2 cycles while locked.
module adc_rst_seq
  import adc_rst_seq_pkg::*;
#(
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int DLYRST_CYC  = DEF_DLYRST_CYC,
  parameter int RDY_TIMEOUT = DEF_RDY_TIMEOUT,
  parameter int SRDRST_CYC  = DEF_SRDRST_CYC
) (
  input  logic       clk_div_a,
  input  logic       bufg_rst,
  input  logic       dly_rdy,
  input  logic       soft_rst,
  output logic       dly_rst,
  output logic       serdes_rst,
  output logic       gclk_sd_lockeda,
  output logic [3:0] retry_cnt,
  output logic [2:0] seq_state
);

  localparam int CNT_MAX = max4(SETTLE_CYC, DLYRST_CYC, RDY_TIMEOUT, SRDRST_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] DLYRST_LAST  = CNT_W'(DLYRST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(RDY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SRDRST_LAST  = CNT_W'(SRDRST_CYC - 1);
  localparam logic [3:0]       RETRY_SAT    = 4'(RETRY_MAX);

  logic             rst_i;
  logic             rdy_s;
  logic             rdy_lost;
  logic             retry_inc;
  logic [2:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  seq_out_t         out_nxt;

  rst_sync3 #(.STAGES(3), .RST_VAL(1'b1)) u_rst_sync (
    .clk  (clk_div_a),
    .arst (bufg_rst),
    .d    (1'b0),
    .q    (rst_i)
  );

  rst_sync3 #(.STAGES(2), .RST_VAL(1'b0)) u_rdy_sync (
    .clk  (clk_div_a),
    .arst (rst_i),
    .d    (dly_rdy),
    .q    (rdy_s)
  );

`ifdef ADC_RST_SEQ_RDY_MON_EN
  // rdy_lo remembers that rdy_s was already low on the previous locked cycle.
  logic rdy_lo;

  always_ff @(posedge clk_div_a or posedge rst_i) begin
    if (rst_i) rdy_lo <= 1'b0;
    else       rdy_lo <= (seq_state == S_LOCKED) && (state_nxt == S_LOCKED) && !rdy_s;
  end

  assign rdy_lost = rdy_lo && !rdy_s;
`else
  assign rdy_lost = 1'b0;
`endif

  always_comb begin
    state_nxt = seq_state;
    retry_inc = 1'b0;
    case (seq_state)
      S_RST:    state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == SETTLE_LAST) state_nxt = S_DLYRST;
      S_DLYRST: if (cnt == DLYRST_LAST) state_nxt = S_WAITRDY;
      S_WAITRDY: begin
        // A ready seen on the timeout cycle takes priority over the retry.
        if (rdy_s) begin
          state_nxt = S_SRDRST;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = S_DLYRST;
          retry_inc = 1'b1;
        end
      end
      S_SRDRST: if (cnt == SRDRST_LAST) state_nxt = S_LOCKED;
      S_LOCKED: if (soft_rst || rdy_lost) state_nxt = S_DLYRST;
      default:  state_nxt = S_RST;
    endcase
  end

  assign out_nxt = decode_out(state_nxt);

  always_ff @(posedge clk_div_a or posedge rst_i) begin
    if (rst_i) begin
      seq_state       <= S_RST;
      dly_rst         <= 1'b1;
      serdes_rst      <= 1'b1;
      gclk_sd_lockeda <= 1'b0;
      retry_cnt       <= 4'd0;
      cnt             <= '0;
    end else begin
      seq_state       <= state_nxt;
      dly_rst         <= out_nxt.dly_rst;
      serdes_rst      <= out_nxt.serdes_rst;
      gclk_sd_lockeda <= out_nxt.lockeda;
      if (retry_inc && (retry_cnt != RETRY_SAT)) retry_cnt <= retry_cnt + 4'd1;
      if (state_nxt != seq_state)   cnt <= '0;
      else if (seq_state != S_LOCKED) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_adc_rst_seq.sv
// Scoreboard bench: stimulus queues expected output transitions, a monitor pops one per observed change.
module tb_adc_rst_seq;

  localparam int T   = 64;
  localparam int PER = 16 + T;

  logic       clk_div_a = 1'b0;
  logic       bufg_rst, dly_rdy, soft_rst;
  logic       dly_rst, serdes_rst, gclk_sd_lockeda;
  logic [3:0] retry_cnt;
  logic [2:0] seq_state;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int         c;
    logic [2:0] st;
    logic       d, s, l;
    logic [3:0] r;
  } exp_t;

  exp_t exp_q[$];
  logic [9:0] prev = 'x;
  logic [9:0] snap;

  adc_rst_seq #(.RDY_TIMEOUT(T)) dut (
    .clk_div_a       (clk_div_a),
    .bufg_rst        (bufg_rst),
    .dly_rdy         (dly_rdy),
    .soft_rst        (soft_rst),
    .dly_rst         (dly_rst),
    .serdes_rst      (serdes_rst),
    .gclk_sd_lockeda (gclk_sd_lockeda),
    .retry_cnt       (retry_cnt),
    .seq_state       (seq_state)
  );

  always #2 clk_div_a = ~clk_div_a;
  always @(posedge clk_div_a) cyc <= cyc + 1;

  task automatic push(input int c, input logic [2:0] st, input logic d, input logic s,
                      input logic l, input logic [3:0] r);
    exp_t e;
    e.c = c; e.st = st; e.d = d; e.s = s; e.l = l; e.r = r;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_div_a);
  endtask

  // Full power-up sequence relative to the negedge where bufg_rst was released.
  task automatic powerup_exp(input int c0);
    push(c0 + 4,   3'd1, 1'b1, 1'b1, 1'b0, 4'd0);
    push(c0 + 260, 3'd2, 1'b1, 1'b1, 1'b0, 4'd0);
    push(c0 + 276, 3'd3, 1'b0, 1'b1, 1'b0, 4'd0);
    push(c0 + 277, 3'd4, 1'b0, 1'b1, 1'b0, 4'd0);
    push(c0 + 285, 3'd5, 1'b0, 1'b0, 1'b1, 4'd0);
  endtask

  always @(negedge clk_div_a) begin
    exp_t e;
    snap = {seq_state, dly_rst, serdes_rst, gclk_sd_lockeda, retry_cnt};
    if (snap !== prev) begin
      prev = snap;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got st=%0d dly=%0b srd=%0b lock=%0b retry=%0d, none expected",
                 cyc, seq_state, dly_rst, serdes_rst, gclk_sd_lockeda, retry_cnt);
      end else begin
        e = exp_q.pop_front();
        if (e.c != cyc || e.st !== seq_state || e.d !== dly_rst || e.s !== serdes_rst ||
            e.l !== gclk_sd_lockeda || e.r !== retry_cnt) begin
          failures++;
          $display("FAIL transition got cyc=%0d st=%0d dly=%0b srd=%0b lock=%0b retry=%0d, want cyc=%0d st=%0d dly=%0b srd=%0b lock=%0b retry=%0d",
                   cyc, seq_state, dly_rst, serdes_rst, gclk_sd_lockeda, retry_cnt,
                   e.c, e.st, e.d, e.s, e.l, e.r);
        end
      end
    end
  end

  initial begin
    int c0, c1, n, p, w, a;
    bufg_rst = 1'b1; dly_rdy = 1'b1; soft_rst = 1'b0;
    push(1, 3'd0, 1'b1, 1'b1, 1'b0, 4'd0);

    // power-up with rdy tied high; soft_rst during settle must be ignored
    wait_until(5);
    c0 = cyc; bufg_rst = 1'b0;
    powerup_exp(c0);
    wait_until(c0 + 100);
    soft_rst = 1'b1; @(negedge clk_div_a); soft_rst = 1'b0;
    wait_until(c0 + 295);

    // soft re-lock from S_LOCKED
    n = cyc; soft_rst = 1'b1; p = n + 1;
    push(p,      3'd2, 1'b1, 1'b1, 1'b0, 4'd0);
    push(p + 16, 3'd3, 1'b0, 1'b1, 1'b0, 4'd0);
    push(p + 17, 3'd4, 1'b0, 1'b1, 1'b0, 4'd0);
    push(p + 25, 3'd5, 1'b0, 1'b0, 1'b1, 4'd0);
    @(negedge clk_div_a); soft_rst = 1'b0;
    wait_until(p + 30);

    // repeated timeouts with rdy low: retry count saturates at 15
    n = cyc; dly_rdy = 1'b0; soft_rst = 1'b1; p = n + 1;
    push(p, 3'd2, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k <= 16; k++) begin
      push(p + 16 + (k - 1) * PER, 3'd3, 1'b0, 1'b1, 1'b0, 4'((k - 1 > 15) ? 15 : k - 1));
      push(p + k * PER,            3'd2, 1'b1, 1'b1, 1'b0, 4'((k > 15) ? 15 : k));
    end
    w = p + 16 * PER + 16;
    push(w,      3'd3, 1'b0, 1'b1, 1'b0, 4'd15);
    push(w + 13, 3'd4, 1'b0, 1'b1, 1'b0, 4'd15);
    push(w + 21, 3'd5, 1'b0, 1'b0, 1'b1, 4'd15);
    @(negedge clk_div_a); soft_rst = 1'b0;
    wait_until(w + 10); dly_rdy = 1'b1;
    wait_until(w + 26);

    // rdy_s rises exactly on the timeout cycle: ready wins, retry untouched
    n = cyc; dly_rdy = 1'b0; soft_rst = 1'b1; p = n + 1; w = p + 16;
    push(p,         3'd2, 1'b1, 1'b1, 1'b0, 4'd15);
    push(w,         3'd3, 1'b0, 1'b1, 1'b0, 4'd15);
    push(w + T,     3'd4, 1'b0, 1'b1, 1'b0, 4'd15);
    push(w + T + 8, 3'd5, 1'b0, 1'b0, 1'b1, 4'd15);
    @(negedge clk_div_a); soft_rst = 1'b0;
    wait_until(w + T - 3); dly_rdy = 1'b1;
    wait_until(w + T + 12);

    // short and long dly_rdy dropouts while locked
    dly_rdy = 1'b0; @(negedge clk_div_a); dly_rdy = 1'b1;
    repeat (6) @(negedge clk_div_a);
    n = cyc; dly_rdy = 1'b0; a = n + 1;
`ifdef ADC_RST_SEQ_RDY_MON_EN
    push(a + 3,  3'd2, 1'b1, 1'b1, 1'b0, 4'd15);
    push(a + 19, 3'd3, 1'b0, 1'b1, 1'b0, 4'd15);
    push(a + 20, 3'd4, 1'b0, 1'b1, 1'b0, 4'd15);
    push(a + 28, 3'd5, 1'b0, 1'b0, 1'b1, 4'd15);
`endif
    repeat (3) @(negedge clk_div_a);
    dly_rdy = 1'b1;
    wait_until(a + 35);

    // async reset from lock, then again mid-settle at counter=100
    wait_until(cyc + 1);
    @(posedge clk_div_a); #1;
    bufg_rst = 1'b1;
    push(cyc, 3'd0, 1'b1, 1'b1, 1'b0, 4'd0);
    repeat (3) @(negedge clk_div_a);
    c0 = cyc; bufg_rst = 1'b0;
    push(c0 + 4, 3'd1, 1'b1, 1'b1, 1'b0, 4'd0);
    wait_until(c0 + 103);
    @(posedge clk_div_a); #1;
    bufg_rst = 1'b1;
    push(cyc, 3'd0, 1'b1, 1'b1, 1'b0, 4'd0);
    repeat (3) @(negedge clk_div_a);
    c1 = cyc; bufg_rst = 1'b0;
    powerup_exp(c1);
    wait_until(c1 + 295);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_transitions got %0d left, want 0 (next want cyc=%0d st=%0d)",
               exp_q.size(), exp_q[0].c, exp_q[0].st);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
